// File: rtl/bp_cce_dir_rd_seq_pkg.sv
// Shared types for the CCE directory way-group read sequencer.
// Coherence states, sequencer FSM encodings and the directory entry layout.
package bp_cce_dir_rd_seq_pkg;

  typedef enum logic [2:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_F = 3'd3,
    e_COH_O = 3'd4,
    e_COH_M = 3'd5
  } bp_coh_states_e;

  localparam int coh_w_gp = $bits(bp_coh_states_e);
  localparam int dir_tag_width_gp = 20;

  localparam logic [1:0] e_DIR_IDLE = 2'd0;
  localparam logic [1:0] e_DIR_READ = 2'd1;
  localparam logic [1:0] e_DIR_LAST = 2'd2;
  localparam logic [1:0] e_DIR_DONE = 2'd3;

  // State sits in the LSBs of each directory entry.
  typedef struct packed {
    logic [dir_tag_width_gp-1:0] tag;
    bp_coh_states_e              state;
  } bp_cce_dir_entry_s;

endpackage

// File: rtl/bp_cce_dir_row_match.sv
// Combinational tag match of one directory row.
// Lowest matching way wins; two or more matching ways flag a multi-hit.
module bp_cce_dir_row_match
  import bp_cce_dir_rd_seq_pkg::*;
#(
  parameter int lces_per_row_p = 2,
  parameter int lce_assoc_p = 8,
  parameter int tag_width_p = 20,
  localparam int sw_lp = coh_w_gp,
  localparam int ew_lp = tag_width_p + sw_lp,
  localparam int way_w_lp = $clog2(lce_assoc_p),
  localparam int row_w_lp = lces_per_row_p*lce_assoc_p*ew_lp
) (
  input  logic [row_w_lp-1:0]                row_i,
  input  logic [tag_width_p-1:0]             tag_i,
  output logic [lces_per_row_p-1:0]          hits_o,
  output logic [lces_per_row_p*way_w_lp-1:0] ways_o,
  output logic [lces_per_row_p*sw_lp-1:0]    states_o,
  output logic                               multi_o
);

  logic [ew_lp-1:0] ent;

  always_comb begin
    hits_o = '0;
    ways_o = '0;
    states_o = '0;
    multi_o = 1'b0;
    ent = '0;
    for (int j = 0; j < lces_per_row_p; j++) begin
      for (int w = 0; w < lce_assoc_p; w++) begin
        ent = row_i[(j*lce_assoc_p+w)*ew_lp +: ew_lp];
        if (ent[ew_lp-1:sw_lp] == tag_i
            && ent[sw_lp-1:0] != e_COH_I) begin
          if (hits_o[j]) begin
            multi_o = 1'b1;
          end else begin
            hits_o[j] = 1'b1;
            ways_o[j*way_w_lp +: way_w_lp] = way_w_lp'(w);
            states_o[j*sw_lp +: sw_lp] = ent[sw_lp-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/bp_cce_dir_rd_seq.sv
// Directory way-group read sequencer for the CCE.
// Reads each row, merges per-LCE matches, then strobes the GAD stage.
module bp_cce_dir_rd_seq
  import bp_cce_dir_rd_seq_pkg::*;
#(
  parameter int num_lce_p = 4,
  parameter int lces_per_row_p = 2,
  parameter int lce_assoc_p = 8,
  parameter int tag_width_p = 20,
  parameter int num_way_groups_p = 64,
  localparam int rows_lp = num_lce_p/lces_per_row_p,
  localparam int sw_lp = coh_w_gp,
  localparam int entry_w_lp = tag_width_p + sw_lp,
  localparam int way_w_lp = $clog2(lce_assoc_p),
  localparam int wg_w_lp = $clog2(num_way_groups_p),
  localparam int addr_w_lp = $clog2(num_way_groups_p*rows_lp),
  localparam int rc_w_lp = (rows_lp > 1) ? $clog2(rows_lp) : 1,
  localparam int row_w_lp = lces_per_row_p*lce_assoc_p*entry_w_lp
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_v_i,
  output logic                          ready_o,
  input  logic [wg_w_lp-1:0]            way_group_i,
  input  logic [tag_width_p-1:0]        tag_i,
  output logic                          ram_v_o,
  output logic [addr_w_lp-1:0]          ram_addr_o,
  input  logic [row_w_lp-1:0]           ram_data_i,
  output logic                          sharers_v_o,
  output logic [num_lce_p-1:0]          sharers_hits_o,
  output logic [num_lce_p*way_w_lp-1:0] sharers_ways_o,
  output logic [num_lce_p*sw_lp-1:0]    sharers_coh_states_o,
  output logic                          gad_v_o,
  output logic                          multi_hit_o
);

  logic [1:0]                    state_r;
  logic [rc_w_lp-1:0]            row_cnt_r;
  logic [rc_w_lp-1:0]            proc_row_r;
  logic                          proc_v_r;
  logic [wg_w_lp-1:0]            wg_r;
  logic [tag_width_p-1:0]        tag_r;
  logic [num_lce_p-1:0]          hits_r;
  logic [num_lce_p*way_w_lp-1:0] ways_r;
  logic [num_lce_p*sw_lp-1:0]    states_r;
  logic                          multi_r;
  logic                          sharers_v_r;

  logic [lces_per_row_p-1:0]          m_hits;
  logic [lces_per_row_p*way_w_lp-1:0] m_ways;
  logic [lces_per_row_p*sw_lp-1:0]    m_states;
  logic                               m_multi;

  logic accept;
  logic last_row;

  assign ready_o = (state_r == e_DIR_IDLE)
                 | (state_r == e_DIR_DONE);
  assign accept = start_v_i & ready_o;
  assign last_row = (row_cnt_r == rc_w_lp'(rows_lp-1));

  assign ram_v_o = (state_r == e_DIR_READ);
  assign ram_addr_o = addr_w_lp'(wg_r) * addr_w_lp'(rows_lp)
                    + addr_w_lp'(row_cnt_r);

  assign gad_v_o = (state_r == e_DIR_DONE);
  assign multi_hit_o = gad_v_o & multi_r;
  assign sharers_v_o = sharers_v_r;
  assign sharers_hits_o = hits_r;
  assign sharers_ways_o = ways_r;
  assign sharers_coh_states_o = states_r;

  bp_cce_dir_row_match #(
    .lces_per_row_p(lces_per_row_p),
    .lce_assoc_p   (lce_assoc_p),
    .tag_width_p   (tag_width_p)
  ) u_match (
    .row_i   (ram_data_i),
    .tag_i   (tag_r),
    .hits_o  (m_hits),
    .ways_o  (m_ways),
    .states_o(m_states),
    .multi_o (m_multi)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_DIR_IDLE;
      row_cnt_r <= '0;
      proc_row_r <= '0;
      proc_v_r <= 1'b0;
      wg_r <= '0;
      tag_r <= '0;
      hits_r <= '0;
      ways_r <= '0;
      states_r <= '0;
      multi_r <= 1'b0;
      sharers_v_r <= 1'b0;
    end else begin
      // Row data lands one cycle after its address was issued.
      proc_v_r <= (state_r == e_DIR_READ);
      proc_row_r <= row_cnt_r;
      if (proc_v_r) begin
        multi_r <= multi_r | m_multi;
        for (int i = 0; i < num_lce_p; i++) begin
          if (proc_row_r == rc_w_lp'(i / lces_per_row_p)) begin
            hits_r[i] <= m_hits[i % lces_per_row_p];
            ways_r[i*way_w_lp +: way_w_lp]
              <= m_ways[(i % lces_per_row_p)*way_w_lp +: way_w_lp];
            states_r[i*sw_lp +: sw_lp]
              <= m_states[(i % lces_per_row_p)*sw_lp +: sw_lp];
          end
        end
      end
      unique case (1'b1)
        (state_r == e_DIR_READ): begin
          if (last_row) state_r <= e_DIR_LAST;
          else row_cnt_r <= row_cnt_r + 1'b1;
        end
        (state_r == e_DIR_LAST): begin
          state_r <= e_DIR_DONE;
          sharers_v_r <= 1'b1;
        end
        ready_o: begin
          if (accept) begin
            state_r <= e_DIR_READ;
            row_cnt_r <= '0;
            wg_r <= way_group_i;
            tag_r <= tag_i;
            hits_r <= '0;
            ways_r <= '0;
            states_r <= '0;
            multi_r <= 1'b0;
            sharers_v_r <= 1'b0;
          end else begin
            state_r <= e_DIR_IDLE;
          end
        end
        default: state_r <= e_DIR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cce_dir_rd_seq.sv
// Scoreboard bench for the directory read sequencer.
// A RAM model serves rows; expected bundles are queued at each start.
module tb_bp_cce_dir_rd_seq;
  import bp_cce_dir_rd_seq_pkg::*;

  localparam int NL = 4, LPR = 2, A = 8, TW = 20, NWG = 64;
  localparam int ROWS = NL/LPR, SW = 3, EW = TW+SW, WW = 3;
  localparam int RW = LPR*A*EW, AW = 7, WGW = 6;

  logic clk = 1'b0;
  logic reset_i, start_v_i, ready_o;
  logic [WGW-1:0] way_group_i;
  logic [TW-1:0] tag_i;
  logic ram_v_o;
  logic [AW-1:0] ram_addr_o;
  logic [RW-1:0] ram_data_i;
  logic sharers_v_o, gad_v_o, multi_hit_o;
  logic [NL-1:0] sharers_hits_o;
  logic [NL*WW-1:0] sharers_ways_o;
  logic [NL*SW-1:0] sharers_coh_states_o;

  always #5 clk = ~clk;

  bp_cce_dir_rd_seq dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .start_v_i           (start_v_i),
    .ready_o             (ready_o),
    .way_group_i         (way_group_i),
    .tag_i               (tag_i),
    .ram_v_o             (ram_v_o),
    .ram_addr_o          (ram_addr_o),
    .ram_data_i          (ram_data_i),
    .sharers_v_o         (sharers_v_o),
    .sharers_hits_o      (sharers_hits_o),
    .sharers_ways_o      (sharers_ways_o),
    .sharers_coh_states_o(sharers_coh_states_o),
    .gad_v_o             (gad_v_o),
    .multi_hit_o         (multi_hit_o)
  );

  logic [RW-1:0] dir [NWG*ROWS];

  always @(posedge clk)
    if (ram_v_o) ram_data_i <= dir[ram_addr_o];

  typedef struct {
    logic [NL-1:0]    hits;
    logic [NL*WW-1:0] ways;
    logic [NL*SW-1:0] st;
    logic             multi;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  logic [AW-1:0] addr_q[$];
  int checks = 0, errors = 0, cyc_n = 0, gad_cnt = 0;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(int wg, logic [TW-1:0] tag, int at);
    exp_t e;
    logic [EW-1:0] ent;
    e.hits = '0; e.ways = '0; e.st = '0; e.multi = 1'b0; e.cyc = at;
    for (int l = 0; l < NL; l++)
      for (int w = 0; w < A; w++) begin
        ent = dir[wg*ROWS + l/LPR][((l%LPR)*A+w)*EW +: EW];
        if (ent[EW-1:SW] == tag && ent[SW-1:0] != 3'd0) begin
          if (e.hits[l]) e.multi = 1'b1;
          else begin
            e.hits[l] = 1'b1;
            e.ways[l*WW +: WW] = WW'(w);
            e.st[l*SW +: SW] = ent[SW-1:0];
          end
        end
      end
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    if (ram_v_o) begin
      check("ram_read_expected", 64'(addr_q.size() > 0), 1);
      if (addr_q.size() > 0) check("ram_addr", ram_addr_o, addr_q.pop_front());
    end
    if (gad_v_o) begin
      gad_cnt++;
      check("gad_expected", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gad_latency", cyc_n, e.cyc);
        check("sharers_v", sharers_v_o, 1);
        check("hits", sharers_hits_o, e.hits);
        check("ways", sharers_ways_o, e.ways);
        check("states", sharers_coh_states_o, e.st);
        check("multi_hit", multi_hit_o, e.multi);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    monitor();
  endtask

  task automatic set_ent(int wg, int l, int w, logic [TW-1:0] tag, bp_coh_states_e s);
    dir[wg*ROWS + l/LPR][((l%LPR)*A+w)*EW +: EW] = {tag, s};
  endtask

  task automatic start(int wg, logic [TW-1:0] tag);
    for (int i = 0; i < 20 && !ready_o; i++) cyc();
    check("ready_before_start", ready_o, 1);
    way_group_i = WGW'(wg);
    tag_i = tag;
    start_v_i = 1'b1;
    exp_q.push_back(model(wg, tag, cyc_n + ROWS + 2));
    for (int r = 0; r < ROWS; r++) addr_q.push_back(AW'(wg*ROWS + r));
    cyc();
    start_v_i = 1'b0;
  endtask

  task automatic wait_gad();
    int n;
    n = gad_cnt;
    for (int i = 0; i < 20 && gad_cnt == n; i++) cyc();
    check("gad_seen", 64'(gad_cnt > n), 1);
  endtask

  initial begin
    int n;
    int wg;
    logic [TW-1:0] t;
    reset_i = 1'b1;
    start_v_i = 1'b0;
    way_group_i = '0;
    tag_i = '0;
    for (int i = 0; i < NWG*ROWS; i++) dir[i] = '0;
    cyc(); cyc();
    check("rst_ready", ready_o, 1);
    check("rst_ram_v", ram_v_o, 0);
    check("rst_sharers_v", sharers_v_o, 0);
    check("rst_gad", gad_v_o, 0);
    check("rst_multi", multi_hit_o, 0);
    check("rst_hits", sharers_hits_o, 0);
    check("rst_ways", sharers_ways_o, 0);
    check("rst_states", sharers_coh_states_o, 0);
    reset_i = 1'b0;
    cyc();

    set_ent(5, 1, 3, 20'h01234, e_COH_S);
    set_ent(5, 2, 6, 20'h01234, e_COH_M);
    set_ent(5, 0, 2, 20'h01234, e_COH_I);
    start(5, 20'h01234);
    wait_gad();
    check("t1_hits", sharers_hits_o, 4'b0110);
    check("t1_ways", sharers_ways_o, 12'h198);
    check("t1_states", sharers_coh_states_o, 12'h148);
    check("t1_multi", multi_hit_o, 0);
    cyc();
    check("t1_hold_v", sharers_v_o, 1);
    check("t1_hold_hits", sharers_hits_o, 4'b0110);

    set_ent(9, 3, 1, 20'h01234, e_COH_E);
    set_ent(9, 3, 4, 20'h01234, e_COH_S);
    start(9, 20'h01234);
    wait_gad();
    check("t3_multi", multi_hit_o, 1);
    check("t3_hits", sharers_hits_o, 4'b1000);
    check("t3_ways", sharers_ways_o, 12'h200);
    check("t3_states", sharers_coh_states_o, 12'h400);
    cyc();
    check("t3_multi_drop", multi_hit_o, 0);

    set_ent(6, 0, 0, 20'hABCDE, e_COH_S);
    start(5, 20'h01234);
    wait_gad();
    start(6, 20'hABCDE);
    check("b2b_addr", ram_addr_o, 12);
    check("b2b_sharers_v", sharers_v_o, 0);
    wait_gad();
    check("b2b_hits", sharers_hits_o, 4'b0001);

    start(9, 20'h01234);
    cyc();
    reset_i = 1'b1;
    #1;
    exp_q.delete();
    addr_q.delete();
    check("mid_rst_ram_v", ram_v_o, 0);
    check("mid_rst_ready", ready_o, 1);
    check("mid_rst_sharers_v", sharers_v_o, 0);
    check("mid_rst_hits", sharers_hits_o, 0);
    check("mid_rst_gad", gad_v_o, 0);
    cyc(); cyc();
    reset_i = 1'b0;
    start(5, 20'h01234);
    wait_gad();
    check("post_rst_hits", sharers_hits_o, 4'b0110);

    n = gad_cnt;
    start(9, 20'h01234);
    way_group_i = 7;
    start_v_i = 1'b1;
    cyc(); cyc();
    start_v_i = 1'b0;
    wait_gad();
    repeat (5) cyc();
    check("busy_gad_count", gad_cnt - n, 1);

    for (int k = 0; k < 4; k++) begin
      wg = (k == 0) ? 63 : int'($urandom_range(10, 62));
      t = TW'($urandom);
      for (int m = 0; m < 6; m++)
        set_ent(wg, int'($urandom_range(0, NL-1)), int'($urandom_range(0, A-1)),
                ($urandom_range(0, 3) == 0) ? TW'($urandom) : t,
                bp_coh_states_e'($urandom_range(0, 5)));
      start(wg, t);
      wait_gad();
    end
    repeat (3) cyc();
    check("queues_drained", 64'(exp_q.size() + addr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
